ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter_pkg.sv | 19 +
 rtl/ddr3_port_arbiter_rr_pick.sv | 29 ++
 rtl/ddr3_port_arbiter.sv | 113 +++++++++++
 tb/tb_ddr3_port_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ddr3_port_arbiter_pkg.sv
// Shared definitions for the DDR3 port arbiter: FSM state encoding and the
// helper used to size port-index fields.
package ddr3_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // Bits needed to hold an index in 0..n-1; never less than one bit.
    function automatic int get_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/ddr3_port_arbiter_rr_pick.sv
// Round-robin winner selection: scans from last_grant+1 (mod N) and returns
// the first requesting port as a one-hot vector. Purely combinational.
module ddr3_port_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_last_grant,
    output logic [N-1:0]  o_winner
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        w_found  = 1'b0;
        for (int off = 1; off <= N; off++) begin
            w_idx = PW'((int'(i_last_grant) + off) % N);
            if (!w_found && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Arbitrates N requester ports onto one registered cache-controller request,
// round-robin, with a one-cycle release gap between transactions.
module ddr3_port_arbiter
    import ddr3_port_arbiter_pkg::*;
#(
    parameter int N  = 3,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*AW-1:0] req_addr_i,
    input  logic [N*32-1:0] req_data_i,
    input  logic [N-1:0]    req_rd_i,
    input  logic [N-1:0]    req_we_i,
    output logic [31:0]     req_data_o,
    output logic [N-1:0]    req_ack_o,
    output logic [31:0]     mem_addr_o,
    output logic [31:0]     mem_data_o,
    output logic            mem_rd_o,
    output logic            mem_we_o,
    input  logic [31:0]     mem_data_i,
    input  logic            mem_ack_i,
    output logic [N-1:0]    grant_o,
    output logic            busy_o
);

    localparam int PW = get_width(N);

    state_t        r_state, w_next;
    logic [N-1:0]  w_req, w_win, r_grant;
    logic [PW-1:0] w_win_idx, r_grant_idx, r_last_grant;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_data;
    logic          w_sel_rd, w_sel_we;
    logic [31:0]   r_mem_addr, r_mem_data;
    logic          r_mem_rd, r_mem_we;

    assign w_req = req_rd_i | req_we_i;

    ddr3_port_arbiter_rr_pick #(.N(N), .PW(PW)) u_rr_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_winner     (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N; i++)
            if (w_win[i]) w_win_idx = PW'(i);
    end

    // A port raising rd and we together is treated as a read only.
    assign w_sel_addr = req_addr_i[w_win_idx*AW +: AW];
    assign w_sel_data = req_data_i[w_win_idx*32 +: 32];
    assign w_sel_rd   = req_rd_i[w_win_idx];
    assign w_sel_we   = req_we_i[w_win_idx] & ~w_sel_rd;

    // NOTE: state and datapath registers use non-blocking assignment only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (|w_req)    w_next = S_BUSY;
            S_BUSY:    if (mem_ack_i) w_next = S_RELEASE;
            S_RELEASE:                w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= PW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: if (|w_req) begin
                    r_mem_addr  <= 32'(w_sel_addr);
                    r_mem_data  <= w_sel_data;
                    r_mem_rd    <= w_sel_rd;
                    r_mem_we    <= w_sel_we;
                    r_grant     <= w_win;
                    r_grant_idx <= w_win_idx;
                end
                S_BUSY: if (mem_ack_i) begin
                    r_mem_rd     <= 1'b0;
                    r_mem_we     <= 1'b0;
                    r_grant      <= '0;
                    r_last_grant <= r_grant_idx;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_o = r_mem_addr;
    assign mem_data_o = r_mem_data;
    assign mem_rd_o   = r_mem_rd;
    assign mem_we_o   = r_mem_we;
    assign grant_o    = r_grant;
    assign busy_o     = (r_state != S_IDLE);
    assign req_data_o = mem_data_i;
    assign req_ack_o  = (mem_ack_i && r_state == S_BUSY) ? r_grant : '0;

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Directed self-checking bench for ddr3_port_arbiter: a table of single-port
// transactions plus hand sequences for arbitration order, reset and spurious acks.
module tb_ddr3_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*AW-1:0] req_addr_i = '0;
    logic [N*32-1:0] req_data_i = '0;
    logic [N-1:0]    req_rd_i   = '0;
    logic [N-1:0]    req_we_i   = '0;
    logic [31:0]     req_data_o;
    logic [N-1:0]    req_ack_o;
    logic [31:0]     mem_addr_o, mem_data_o;
    logic            mem_rd_o, mem_we_o;
    logic [31:0]     mem_data_i = '0;
    logic            mem_ack_i  = 1'b0;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    ddr3_port_arbiter #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_rd_i   (req_rd_i),
        .req_we_i   (req_we_i),
        .req_data_o (req_data_o),
        .req_ack_o  (req_ack_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Requests must already be driven so the next posedge (in S_IDLE) arbitrates.
    // Ack arrives 'delay' cycles after the grant becomes visible.
    task automatic run_txn(input string tag, input logic [2:0] g, input int delay,
                           input bit e_rd, input bit e_we,
                           input logic [31:0] e_addr, input logic [31:0] e_data,
                           input logic [31:0] rdata);
        logic [N*AW-1:0] sa;
        logic [N*32-1:0] sd;
        @(negedge clk);
        check({tag, ":grant"}, 32'(grant_o), 32'(g));
        check({tag, ":busy"}, 32'(busy_o), 32'd1);
        check({tag, ":mem_rd"}, 32'(mem_rd_o), 32'(e_rd));
        check({tag, ":mem_we"}, 32'(mem_we_o), 32'(e_we));
        check({tag, ":mem_addr"}, mem_addr_o, e_addr);
        check({tag, ":mem_data"}, mem_data_o, e_data);
        sa = req_addr_i;
        sd = req_data_i;
        for (int i = 0; i < delay; i++) begin
            req_addr_i = {$urandom, $urandom, $urandom};
            req_data_i = {$urandom, $urandom, $urandom};
            @(negedge clk);
            check({tag, ":hold_addr"}, mem_addr_o, e_addr);
            check({tag, ":hold_rd"}, 32'(mem_rd_o), 32'(e_rd));
            check({tag, ":no_early_ack"}, 32'(req_ack_o), 32'd0);
        end
        req_addr_i = sa;
        req_data_i = sd;
        mem_ack_i  = 1'b1;
        mem_data_i = rdata;
        #1;
        check({tag, ":ack"}, 32'(req_ack_o), 32'(g));
        check({tag, ":rdata"}, req_data_o, rdata);
        @(negedge clk);
        mem_ack_i = 1'b0;
        req_rd_i  = req_rd_i & ~g;
        req_we_i  = req_we_i & ~g;
        check({tag, ":rel_busy"}, 32'(busy_o), 32'd1);
        check({tag, ":rel_grant"}, 32'(grant_o), 32'd0);
        check({tag, ":rel_rd_we"}, {30'd0, mem_rd_o, mem_we_o}, 32'd0);
        @(negedge clk);
        check({tag, ":idle_busy"}, 32'(busy_o), 32'd0);
        check({tag, ":idle_ack"}, 32'(req_ack_o), 32'd0);
    endtask

    typedef struct {
        int          port;
        bit          rd;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        bit          exp_rd;
        bit          exp_we;
        logic [2:0]  exp_grant;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hCAFE_0001, 5, 1'b1, 1'b0, 3'b010};
        vecs[1] = '{0, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h1234_ABCD, 2, 1'b1, 1'b0, 3'b001};
        vecs[2] = '{2, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'h0000_0000, 1, 1'b0, 1'b1, 3'b100};
        vecs[3] = '{0, 1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 32'h0000_0000, 0, 1'b0, 1'b1, 3'b001};

        #2 rst = 1'b1;
        @(negedge clk);
        check("reset:grant", 32'(grant_o), 32'd0);
        check("reset:busy", 32'(busy_o), 32'd0);
        check("reset:rd_we", {30'd0, mem_rd_o, mem_we_o}, 32'd0);
        check("reset:addr", mem_addr_o, 32'd0);
        check("reset:data", mem_data_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            req_addr_i[vecs[v].port*AW +: AW] = vecs[v].addr;
            req_data_i[vecs[v].port*32 +: 32] = vecs[v].wdata;
            req_rd_i[vecs[v].port] = vecs[v].rd;
            req_we_i[vecs[v].port] = vecs[v].we;
            run_txn($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].delay,
                    vecs[v].exp_rd, vecs[v].exp_we, vecs[v].addr, vecs[v].wdata, vecs[v].rdata);
        end

        // Spurious ack while idle must be ignored.
        mem_ack_i = 1'b1;
        #1;
        check("spurious:ack", 32'(req_ack_o), 32'd0);
        @(negedge clk);
        mem_ack_i = 1'b0;
        check("spurious:busy", 32'(busy_o), 32'd0);
        check("spurious:grant", 32'(grant_o), 32'd0);
        check("spurious:rd", 32'(mem_rd_o), 32'd0);

        // Reset during S_BUSY; the last completed grant was port 0, so without a
        // reset the next all-port arbitration would start at port 1.
        req_addr_i = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        req_data_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        req_rd_i   = 3'b010;
        @(negedge clk);
        check("abort:busy_before", 32'(busy_o), 32'd1);
        check("abort:grant_before", 32'(grant_o), 32'd2);
        rst       = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        check("abort:grant", 32'(grant_o), 32'd0);
        check("abort:busy", 32'(busy_o), 32'd0);
        check("abort:rd", 32'(mem_rd_o), 32'd0);
        check("abort:addr", mem_addr_o, 32'd0);
        check("abort:no_ack", 32'(req_ack_o), 32'd0);
        @(negedge clk);
        check("abort:no_ack_held", 32'(req_ack_o), 32'd0);
        rst       = 1'b0;
        mem_ack_i = 1'b0;
        req_rd_i  = 3'b111;

        // All three read together: served 0,1,2 with an idle cycle between.
        run_txn("all0", 3'b001, 1, 1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h0000_00A0);
        run_txn("all1", 3'b010, 1, 1'b1, 1'b0, 32'h0000_2000, 32'h2222_2222, 32'h0000_00A1);
        run_txn("all2", 3'b100, 1, 1'b1, 1'b0, 32'h0000_3000, 32'h3333_3333, 32'h0000_00A2);

        // Port 2 write held while ports 0/1 re-request after every transaction.
        req_rd_i = 3'b011;
        req_we_i = 3'b100;
        run_txn("sat0", 3'b001, 0, 1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 32'h0);
        req_rd_i[0] = 1'b1;
        run_txn("sat1", 3'b010, 0, 1'b1, 1'b0, 32'h0000_2000, 32'h2222_2222, 32'h0);
        req_rd_i[1] = 1'b1;
        run_txn("sat2", 3'b100, 0, 1'b0, 1'b1, 32'h0000_3000, 32'h3333_3333, 32'h0);
        check("sat:port2_served", 32'(req_we_i), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
